bus_sram_responder: RTL and testbench

- Single-port word-wide SRAM that sits on the slave end of bus_if and answers master requests from the TTA core's instruction fetch and data paths.
- Decodes a configurable address window and applies byte-lane writes.
- Adds a programmable number of wait states before ready, so masters can be exercised against non-zero-latency memory.

---
 rtl/bus_sram_responder_if.sv | 20 ++
 rtl/bus_sram_responder.sv | 127 ++++++++++++
 tb/tb_bus_sram_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_sram_responder_if.sv
// Request/response bus between a TTA core master and a memory slave.
interface bus_if;
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] write_data;
    logic        instr;
    logic        ready;
    logic [31:0] read_data;

    modport master (
        output valid, addr, wstrb, write_data, instr,
        input  ready, read_data
    );

    modport slave (
        input  valid, addr, wstrb, write_data, instr,
        output ready, read_data
    );
endinterface

// File: rtl/bus_sram_responder.sv
// Word-wide SRAM slave on bus_if with address window, byte lanes and programmable wait states.
// Optional macro BUS_SRAM_INSTR_GUARD_EN blocks instruction-side writes and flags them.
module bus_sram_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] OOR_DATA    = 32'h0000_0000
) (
    input  logic clk_i,
    input  logic rst_ni,
    bus_if.slave bus
`ifdef BUS_SRAM_INSTR_GUARD_EN
    ,
    output logic instr_wr_err_o
`endif
);

    localparam int          ADDR_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] SPAN      = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state, state_next;
    logic [3:0]          wait_cnt, wait_cnt_next;
    logic [31:0]         offset;
    logic                in_range;
    logic [ADDR_W-1:0]   index;
    logic                accept;
    logic                is_write;
    logic                illegal;
    logic                do_write;
    logic [31:0]         mem [MEM_WORDS];
    logic [31:0]         rdata_q;

    // The 33-bit compare keeps a window ending at 2^32 from wrapping into range.
    assign offset   = bus.addr - BASE_ADDR;
    assign in_range = (bus.addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign index    = ADDR_W'(offset >> 2);
    assign accept   = (state == IDLE) && bus.valid;
    assign is_write = |bus.wstrb;

`ifdef BUS_SRAM_INSTR_GUARD_EN
    assign illegal = bus.instr && is_write;
`else
    assign illegal = 1'b0;
`endif

    assign do_write = accept && is_write && in_range && !illegal;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (bus.valid) begin
                    if (WAIT_STATES > 0) begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready     = (state == RESP);
        bus.read_data = rdata_q;
    end

    // Array has no reset so it stays intact across rst_ni.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.wstrb[k]) begin
                    mem[index][8*k +: 8] <= bus.write_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 32'h0;
        end else if (accept) begin
            if (is_write) begin
                rdata_q <= 32'h0;
            end else if (in_range) begin
                rdata_q <= mem[index];
            end else begin
                rdata_q <= OOR_DATA;
            end
        end
    end

`ifdef BUS_SRAM_INSTR_GUARD_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_wr_err_o <= 1'b0;
        end else if (accept && illegal) begin
            instr_wr_err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_sram_responder.sv
// Self-checking bench: two responders (zero-wait at 0x0, three-wait 16-word window at 0x1000)
// checked against an associative-array memory model.
module tb_bus_sram_responder;

`ifdef BUS_SRAM_INSTR_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_if bus0();
    bus_if bus1();

    logic        valid_d  [2];
    logic [31:0] addr_d   [2];
    logic [3:0]  wstrb_d  [2];
    logic [31:0] wdata_d  [2];
    logic        instr_d  [2];
    logic        ready_d  [2];
    logic [31:0] rdata_d  [2];

    assign bus0.valid      = valid_d[0];
    assign bus0.addr       = addr_d[0];
    assign bus0.wstrb      = wstrb_d[0];
    assign bus0.write_data = wdata_d[0];
    assign bus0.instr      = instr_d[0];
    assign bus1.valid      = valid_d[1];
    assign bus1.addr       = addr_d[1];
    assign bus1.wstrb      = wstrb_d[1];
    assign bus1.write_data = wdata_d[1];
    assign bus1.instr      = instr_d[1];
    assign ready_d[0] = bus0.ready;
    assign rdata_d[0] = bus0.read_data;
    assign ready_d[1] = bus1.ready;
    assign rdata_d[1] = bus1.read_data;

`ifdef BUS_SRAM_INSTR_GUARD_EN
    logic err0, err1;
`endif

    bus_sram_responder #(
        .MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0), .OOR_DATA(32'h0000_0000)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0)
`ifdef BUS_SRAM_INSTR_GUARD_EN
        , .instr_wr_err_o(err0)
`endif
    );

    bus_sram_responder #(
        .MEM_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3), .OOR_DATA(32'hDEAD_BEEF)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus1)
`ifdef BUS_SRAM_INSTR_GUARD_EN
        , .instr_wr_err_o(err1)
`endif
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    bit [31:0] model_mem [int];

    function automatic longint base_of(int d);
        return (d == 0) ? 64'h0 : 64'h1000;
    endfunction

    function automatic longint words_of(int d);
        return (d == 0) ? 64'd1024 : 64'd16;
    endfunction

    function automatic int latency_of(int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] oor_of(int d);
        return (d == 0) ? 32'h0 : 32'hDEAD_BEEF;
    endfunction

    // Applies one request to the model and returns the read_data the responder must show.
    function automatic logic [31:0] model_access(int d, logic [31:0] a, logic [3:0] s,
                                                 logic [31:0] wd, logic ins);
        longint    off;
        bit        inr;
        int        key;
        bit [31:0] word;
        off = longint'({32'h0, a}) - base_of(d);
        inr = (off >= 0) && (off < words_of(d) * 4);
        key = d * 65536 + int'(off / 4);
        if (s != 4'h0) begin
            if (inr && !(GUARD && ins)) begin
                word = model_mem.exists(key) ? model_mem[key] : 32'h0;
                for (int k = 0; k < 4; k++) begin
                    if (s[k]) word[8*k +: 8] = wd[8*k +: 8];
                end
                model_mem[key] = word;
            end
            return 32'h0;
        end
        return inr ? model_mem[key] : oor_of(d);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the responder idle; returns the response data.
    task automatic applyStimulus(input int d, input logic [31:0] a, input logic [3:0] s,
                                 input logic [31:0] wd, input logic ins, input bit drop_early,
                                 output logic [31:0] rd);
        logic [31:0] exp;
        int          cyc;
        exp = model_access(d, a, s, wd, ins);
        valid_d[d] = 1'b1;
        addr_d[d]  = a;
        wstrb_d[d] = s;
        wdata_d[d] = wd;
        instr_d[d] = ins;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (drop_early && cyc == 1) valid_d[d] = 1'b0;
        end while (!ready_d[d] && cyc < 40);
        rd = rdata_d[d];
        valid_d[d] = 1'b0;
        checkOutput($sformatf("latency d%0d a%h", d, a), 32'(cyc), 32'(latency_of(d)));
        checkOutput($sformatf("ready d%0d a%h", d, a), 32'(ready_d[d]), 32'h1);
        checkOutput($sformatf("rdata d%0d a%h", d, a), rd, exp);
        @(negedge clk);
        checkOutput($sformatf("ready_drop d%0d", d), 32'(ready_d[d]), 32'h0);
        checkOutput($sformatf("rdata_hold d%0d", d), rdata_d[d], exp);
    endtask

    initial begin
        logic [31:0] rd, prev, a, wd;
        logic [3:0]  s;
        int          d, r;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid_d[i] = 1'b0; addr_d[i] = 32'h0; wstrb_d[i] = 4'h0;
            wdata_d[i] = 32'h0; instr_d[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset ready0", 32'(ready_d[0]), 32'h0);
        checkOutput("reset rdata0", rdata_d[0], 32'h0);
        checkOutput("reset ready1", 32'(ready_d[1]), 32'h0);
        checkOutput("reset rdata1", rdata_d[1], 32'h0);
`ifdef BUS_SRAM_INSTR_GUARD_EN
        checkOutput("reset err0", 32'(err0), 32'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] preloading");
        for (int i = 0; i < 32; i++) applyStimulus(0, 32'(i * 4), 4'hF, $urandom, 1'b0, 1'b0, rd);
        for (int i = 0; i < 16; i++) applyStimulus(1, 32'h1000 + 32'(i * 4), 4'hF, $urandom, 1'b0, 1'b0, rd);

        $display("[TB] full word write/read");
        applyStimulus(0, 32'h10, 4'hF, 32'hCAFE_BABE, 1'b0, 1'b0, rd);
        applyStimulus(0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("t1 read 0x10", rd, 32'hCAFE_BABE);

        $display("[TB] byte lanes");
        applyStimulus(0, 32'h20, 4'hF, 32'h1122_3344, 1'b0, 1'b0, rd);
        applyStimulus(0, 32'h20, 4'b0101, 32'hAABB_CCDD, 1'b0, 1'b0, rd);
        applyStimulus(0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("t2 lanes 0x20", rd, 32'h11BB_33DD);

        $display("[TB] window edges");
        applyStimulus(1, 32'h1040, 4'h0, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("t4 oor read 0x1040", rd, 32'hDEAD_BEEF);
        applyStimulus(1, 32'h103C, 4'h0, 32'h0, 1'b0, 1'b0, prev);
        applyStimulus(1, 32'h0FFC, 4'hF, 32'h1234_5678, 1'b0, 1'b0, rd);
        applyStimulus(1, 32'h1040, 4'hF, 32'h8765_4321, 1'b0, 1'b0, rd);
        applyStimulus(1, 32'h103C, 4'h0, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("t4 word15 untouched", rd, prev);
        applyStimulus(1, 32'h103C, 4'hF, 32'h600D_F00D, 1'b0, 1'b0, rd);
        applyStimulus(1, 32'h103E, 4'h0, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("t4 word15 written", rd, 32'h600D_F00D);

        $display("[TB] valid dropped during wait");
        applyStimulus(1, 32'h1008, 4'h0, 32'h0, 1'b0, 1'b1, rd);
        applyStimulus(1, 32'h1008, 4'hF, 32'h0BAD_CAFE, 1'b0, 1'b1, rd);
        applyStimulus(1, 32'h1008, 4'h0, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("t3 dropped write landed", rd, 32'h0BAD_CAFE);

        $display("[TB] reset mid-wait");
        applyStimulus(1, 32'h1004, 4'h0, 32'h0, 1'b0, 1'b0, rd);
        valid_d[1] = 1'b1; addr_d[1] = 32'h1004; wstrb_d[1] = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        valid_d[1] = 1'b0;
        #1;
        checkOutput("t5 rst ready1", 32'(ready_d[1]), 32'h0);
        checkOutput("t5 rst rdata1", rdata_d[1], 32'h0);
        checkOutput("t5 rst rdata0", rdata_d[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t5 post ready1", 32'(ready_d[1]), 32'h0);
        end
        checkOutput("t5 post rdata1", rdata_d[1], 32'h0);
        applyStimulus(1, 32'h1008, 4'h0, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("t5 data survives reset", rd, 32'h0BAD_CAFE);
        applyStimulus(0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("t5 data0 survives reset", rd, 32'h11BB_33DD);

        $display("[TB] instruction-side write");
        applyStimulus(0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, prev);
        applyStimulus(0, 32'h0, 4'hF, 32'h5A5A_5A5A, 1'b1, 1'b0, rd);
        checkOutput("t6 instr write rdata", rd, 32'h0);
        applyStimulus(0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("t6 instr write effect", rd, GUARD ? prev : 32'h5A5A_5A5A);
`ifdef BUS_SRAM_INSTR_GUARD_EN
        checkOutput("t6 err set", 32'(err0), 32'h1);
        checkOutput("t6 err other dut", 32'(err1), 32'h0);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 160; i++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 99));
            if (d == 0) begin
                a = (r < 85) ? 32'($urandom_range(0, 31)) * 4
                             : 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            end else if (r < 70) begin
                a = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            end else if (r < 85) begin
                a = 32'h1040 + 32'($urandom_range(0, 15)) * 4;
            end else begin
                a = 32'h0FC0 + 32'($urandom_range(0, 15)) * 4;
            end
            a[1:0] = 2'($urandom_range(0, 3));
            s  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            wd = $urandom;
            applyStimulus(d, a, s, wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd);
        end

`ifdef BUS_SRAM_INSTR_GUARD_EN
        checkOutput("err sticky", 32'(err0), 32'h1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
